// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: FSM state encoding, default count
// width and the counter-interface bundle.
package counter_sched_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                 set;
        logic                 ena;
        logic [DEF_CNT_W-1:0] num;
    } cnt_if_t;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// searching upward with wrap at N_REQ.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Priority scan starting at the pointer; the first hit masks the rest.
    always_comb begin
        int   pos_s;
        logic hit_s;
        grant = {N_REQ{1'b0}};
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        pos_s = 0;
        hit_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pos_s        = (int'(ptr) + i) % N_REQ;
            hit_s        = !valid && req[pos_s];
            grant[pos_s] = grant[pos_s] | hit_s;
            idx          = hit_s ? IDX_W'(pos_s) : idx;
            valid        = valid | hit_s;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one down-counter among N_REQ requesters.
// All outputs are registered from the next-state decode.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*CNT_W-1:0] i_count_num,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic                   o_cnt_set,
    output logic                   o_cnt_ena,
    output logic [CNT_W-1:0]       o_cnt_num,
    input  logic                   i_cnt_done
);

    // Same layout as cnt_if_t, sized to this instance's count width.
    typedef struct packed {
        logic             set;
        logic             ena;
        logic [CNT_W-1:0] num;
    } cnt_bus_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] ptr_r, idx_r, idx_s, ptr_wrap_s, arb_idx_s;
    logic [CNT_W-1:0] cnt_r, count_s, sel_count_s;
    logic [N_REQ-1:0] arb_grant_s, onehot_s, grant_s, done_s;
    logic             arb_valid_s, abandon_s, busy_s;
    cnt_bus_t         cnt_bus_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    assign sel_count_s = i_count_num[int'(arb_idx_s)*CNT_W +: CNT_W];

    // Abandonment, wrapped pointer and the index/count that the next state uses.
    always_comb begin
        abandon_s  = ((state_r == LOAD) || (state_r == RUN)) && !i_req[idx_r];
        ptr_wrap_s = (idx_r == IDX_W'(N_REQ-1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        idx_s      = (state_r == IDLE) ? arb_idx_s : idx_r;
        count_s    = (state_r == IDLE) ? sel_count_s : cnt_r;
        onehot_s   = {{(N_REQ-1){1'b0}}, 1'b1} << idx_s;
    end

    // State register, grant latch and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            ptr_r   <= {IDX_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && arb_valid_s) begin
                idx_r <= arb_idx_s;
                cnt_r <= sel_count_s;
            end
            if ((state_r == DONE) || abandon_s) begin
                ptr_r <= ptr_wrap_s;
            end
        end
    end

    // Next-state logic; a zero count skips the counter entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_s = (sel_count_s == {CNT_W{1'b0}}) ? DONE : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (abandon_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (abandon_s) begin
                    state_s = IDLE;
                end else if (i_cnt_done) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        busy_s        = (state_s != IDLE);
        grant_s       = busy_s ? onehot_s : {N_REQ{1'b0}};
        done_s        = (state_s == DONE) ? onehot_s : {N_REQ{1'b0}};
        cnt_bus_s.set = (state_s == LOAD);
        cnt_bus_s.ena = (state_s == RUN);
        cnt_bus_s.num = (state_s == LOAD) ? count_s : {CNT_W{1'b0}};
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant   <= {N_REQ{1'b0}};
            o_done    <= {N_REQ{1'b0}};
            o_busy    <= 1'b0;
            o_cnt_set <= 1'b0;
            o_cnt_ena <= 1'b0;
            o_cnt_num <= {CNT_W{1'b0}};
        end else begin
            o_grant   <= grant_s;
            o_done    <= done_s;
            o_busy    <= busy_s;
            o_cnt_set <= cnt_bus_s.set;
            o_cnt_ena <= cnt_bus_s.ena;
            o_cnt_num <= cnt_bus_s.num;
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched with a behavioural down-counter model.
module tb_counter_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [N-1:0] req;
    logic [N*W-1:0] cnum;
    logic [N-1:0] grant, done;
    logic         busy, cset, cena, cdone;
    logic [W-1:0] cout;

    always #5 clk = ~clk;

    counter_sched #(.N_REQ(N), .CNT_W(W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req       (req),
        .i_count_num (cnum),
        .o_grant     (grant),
        .o_done      (done),
        .o_busy      (busy),
        .o_cnt_set   (cset),
        .o_cnt_ena   (cena),
        .o_cnt_num   (cout),
        .i_cnt_done  (cdone)
    );

    typedef struct {
        int idx;
        int count;
        bit abort;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   busy_prev  = 1'b0;

    // Down-counter model plus per-service bookkeeping.
    logic [W-1:0] mcnt;
    logic         mdone;
    int           dec_cnt;
    bit           set_seen;
    assign cdone = mdone;

    always @(posedge clk) begin
        if (i_rst) begin
            mcnt <= '0; mdone <= 1'b0; dec_cnt <= 0; set_seen <= 1'b0;
        end else begin
            if (done != 0) begin
                dec_cnt <= 0; set_seen <= 1'b0;
            end
            if (cset) begin
                mcnt <= cout; mdone <= 1'b0; dec_cnt <= 0; set_seen <= 1'b1;
            end else if (cena && mcnt != 0) begin
                mcnt <= mcnt - 8'd1;
                if (mcnt == 8'd1) mdone <= 1'b1;
                dec_cnt <= dec_cnt + 1;
            end
        end
    end

    function automatic int oh(input int k);
        return 1 << k;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: invariants every busy cycle, scoreboard pops on load/done/abort.
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            check("grant_onehot", $countones(grant), 1);
            check("set_ena_excl", int'(cset & cena), 0);
            if (!cset) check("num_zero_outside_load", int'(cout), 0);
        end
        if (cset) begin
            if (q.size() == 0) check("unexpected_set", 1, 0);
            else begin
                check("set_num", int'(cout), q[0].count);
                check("set_grant", int'(grant), oh(q[0].idx));
            end
        end
        if (done != 0) begin
            if (q.size() == 0) check("unexpected_done", int'(done), 0);
            else begin
                e = q.pop_front();
                check("done_idx", int'(done), oh(e.idx));
                check("done_grant", int'(grant), oh(e.idx));
                check("done_not_aborted", int'(e.abort), 0);
                check("ena_cycles", dec_cnt, e.count);
                check("set_seen", int'(set_seen), int'(e.count != 0));
            end
        end
        if (busy_prev && !busy && q.size() > 0 && q[0].abort) begin
            e = q.pop_front();
            check("abort_early", int'(dec_cnt < e.count), 1);
        end
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int count, input bit abort);
        exp_t e;
        e.idx = idx; e.count = count; e.abort = abort;
        q.push_back(e);
    endtask

    task automatic do_reset(input string name);
        i_rst = 1'b1;
        tick();
        check(name, int'({grant, done, busy, cset, cena, cout}), 0);
        i_rst = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(name, q.size(), 0);
        if (q.size() != 0) q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; req = '0; cnum = '0;

        // Single request, count 5; then pointer=3 shows as req3 beating req0.
        do_reset("t1_reset");
        tick();
        cnum[2*W +: W] = 8'd5; req = 4'b0100; push(2, 5, 1'b0);
        tick();
        check("t1_set_latency", int'(cset), 1);
        check("t1_num", int'(cout), 5);
        wait_empty(50, "t1_drain");
        check("t1_busy_low", int'(busy), 0);
        req = '0;
        tick();
        cnum[0 +: W] = 8'd1; cnum[3*W +: W] = 8'd1;
        req = 4'b1001; push(3, 1, 1'b0); push(0, 1, 1'b0);
        wait_empty(50, "t1_ptr_drain");
        req = '0;

        // All four requesting and held: order 0,1,2,3,0.
        do_reset("t2_reset");
        cnum = {8'd6, 8'd5, 8'd4, 8'd3};
        req = 4'b1111;
        push(0, 3, 1'b0); push(1, 4, 1'b0); push(2, 5, 1'b0); push(3, 6, 1'b0); push(0, 3, 1'b0);
        wait_empty(300, "t2_drain");
        req = '0;

        // Zero count: straight to DONE, counter untouched.
        do_reset("t3_reset");
        cnum = '0; req = 4'b0010; push(1, 0, 1'b0);
        tick();
        check("t3_done_pulse", int'(done), oh(1));
        check("t3_no_counter", int'(cset | cena), 0);
        wait_empty(20, "t3_drain");
        req = '0;

        // Abandonment mid-RUN, pending req0 served next.
        do_reset("t4_reset");
        cnum[3*W +: W] = 8'd10; req = 4'b1000; push(3, 10, 1'b1);
        tick();
        cnum[0 +: W] = 8'd2; req = 4'b1001; push(0, 2, 1'b0);
        tick(); tick(); tick();
        req = 4'b0001;
        tick();
        check("t4_ena_dropped", int'(cena), 0);
        check("t4_no_done", int'(done), 0);
        check("t4_idle", int'(busy), 0);
        wait_empty(50, "t4_drain");
        req = '0;

        // Reset during RUN of req1; req1 then req2 afterwards.
        do_reset("t5_reset");
        cnum[1*W +: W] = 8'd20; req = 4'b0010; push(1, 20, 1'b1);
        tick(); tick(); tick(); tick();
        cnum[2*W +: W] = 8'd3; req = 4'b0110;
        tick();
        do_reset("t5_mid_reset");
        push(1, 20, 1'b0); push(2, 3, 1'b0);
        wait_empty(200, "t5_drain");
        req = '0;

        // Max count, granted slice changed during RUN.
        do_reset("t6_reset");
        cnum = '0; cnum[0 +: W] = 8'd255; req = 4'b0001; push(0, 255, 1'b0);
        tick(); tick(); tick();
        cnum[0 +: W] = 8'd7;
        wait_empty(600, "t6_drain");
        req = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
